// File: rtl/mult_div.sv
// rtl/mult_div.sv - iterative HI/LO multiply/divide unit for the execute stage
//
// Computes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring
// shift-subtract) over WIDTH iterations plus one sign-fix cycle, and
// handles MTHI/MTLO in a single cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   start        request pulse, sampled only while idle
//   op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a            rs operand (multiplicand / dividend / MTHI-MTLO data)
//   b            rt operand (multiplier / divisor)
//   abort        synchronous cancel (pipeline flush)
//   busy         high while an operation is in flight
//   done         one-cycle pulse when a MULT/DIV result is written
//   div_by_zero  one-cycle pulse alongside done when the divisor was zero
//   hi, lo       HI/LO registers
module mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;       // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;     // negate product/quotient in FIX
  logic               neg_r;     // negate remainder in FIX
  logic               dz;

  // Operand capture
  logic             op_signed;
  logic             arith_req;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_signed = ~op[0];
  assign arith_req = start & ~abort & ~op[2];
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  // One iteration step of each algorithm
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd};
  // A borrow out of the trial subtraction means "restore"; the remainder
  // always fits WIDTH bits because it stays below the divisor.
  assign div_next  = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      acc[WIDTH-2:0], ~div_diff[WIDTH]};

  // Sign-corrected results used in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q ? -acc : acc;
  // With a zero divisor the restoring loop leaves the dividend magnitude as
  // remainder, so re-applying the dividend sign yields the raw captured a.
  assign quo_fix  = dz ? {WIDTH{1'b1}} :
                    (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort wins in every state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arith_req) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      acc         <= '0;
      opd         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            case (op)
              3'b100: hi <= a;
              3'b101: lo <= a;
              3'b000, 3'b001: begin
                acc    <= {{WIDTH{1'b0}}, b_mag};
                opd    <= a_mag;
                is_div <= 1'b0;
                neg_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= op_signed & a[WIDTH-1];
                dz     <= 1'b0;
                cnt    <= '0;
              end
              3'b010, 3'b011: begin
                acc    <= {{WIDTH{1'b0}}, a_mag};
                opd    <= b_mag;
                is_div <= 1'b1;
                neg_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= op_signed & a[WIDTH-1];
                dz     <= (b == '0);
                cnt    <= '0;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!abort) begin
            if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              lo <= prod_fix[WIDTH-1:0];
              hi <= prod_fix[2*WIDTH-1:WIDTH];
            end
            done        <= 1'b1;
            div_by_zero <= dz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - self-checking bench for mult_div against an arithmetic reference model
module tb_mult_div;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MTHI = 3'd4, MTLO = 3'd5;

  mult_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output bit ed);
    logic [63:0] p;
    longint      sx, sy, q, r;
    ed = 1'b0;
    eh = '0;
    el = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MULT: begin
        p  = sx * sy;
        eh = p[63:32];
        el = p[31:0];
      end
      MULTU: begin
        p  = {32'd0, x} * {32'd0, y};
        eh = p[63:32];
        el = p[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          ed = 1'b1;
          el = 32'hFFFF_FFFF;
          eh = x;
        end else if (o == DIV) begin
          q  = sx / sy;
          r  = sx % sy;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", busy, 1'b1);
  endtask

  // elapsed = edges already taken since the start edge
  task automatic wait_done(input string tag, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int elapsed);
    int          n;
    int          nb;
    logic [31:0] eh, el;
    bit          ed;
    n  = elapsed;
    nb = 1 + elapsed;
    model(o, x, y, eh, el, ed);
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) nb++;
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_busy_cycles"}, nb, 33);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_dbz"}, div_by_zero, ed);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    launch(o, x, y);
    wait_done(tag, o, x, y, 0);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] x);
    logic [31:0] old_hi, old_lo;
    old_hi = hi;
    old_lo = lo;
    op = o; a = x; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_hi"}, hi, (o == MTHI) ? x : old_hi);
    check({tag, "_lo"}, lo, (o == MTLO) ? x : old_lo);
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          seen;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    rst = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    tick();
    tick();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b1;
    tick();

    // abort in idle suppresses MTHI; 110 is a no-op
    op = MTHI; a = 32'h55; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_hi", hi, 32'd0);
    op = 3'b110; a = 32'h77; b = 32'h3; start = 1'b1;
    tick();
    start = 1'b0;
    check("nop_busy", busy, 1'b0);
    check("nop_lo", lo, 32'd0);

    // directed cases
    run_op("mult_neg", MULT, 32'hFFFF_FFFF, 32'd2);
    run_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2);
    move_to("mthi", MTHI, 32'h1234_5678);
    move_to("mtlo", MTLO, 32'h9ABC_DEF0);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_zero", DIVU, 32'd100, 32'd0);
    run_op("div_zero_neg", DIV, 32'hFFFF_FF00, 32'd0);
    run_op("divu", DIVU, 32'd100, 32'd7);

    // start during busy is ignored
    launch(DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    op = MULT; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignored", DIVU, 32'd100, 32'd7, 10);
    tick();

    // back-to-back: second start coincides with done
    launch(MULT, 32'h1234_5678, 32'hFEDC_BA98);
    wait_done("b2b_1", MULT, 32'h1234_5678, 32'hFEDC_BA98, 0);
    launch(DIV, 32'h8765_4321, 32'd13);
    wait_done("b2b_2", DIV, 32'h8765_4321, 32'd13, 0);
    tick();

    // abort during RUN leaves hi/lo untouched
    move_to("pre_hi", MTHI, 32'hAAAA_AAAA);
    move_to("pre_lo", MTLO, 32'hAAAA_AAAA);
    launch(MULT, 32'd3, 32'd4);
    repeat (19) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_hi", hi, 32'hAAAA_AAAA);
    check("abort_lo", lo, 32'hAAAA_AAAA);

    // abort in FIX wins over the write
    launch(MULT, 32'd3, 32'd4);
    repeat (32) tick();
    check("fix_busy", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("fixabort_done", done, 1'b0);
    check("fixabort_busy", busy, 1'b0);
    check("fixabort_lo", lo, 32'hAAAA_AAAA);

    // asynchronous reset mid-operation
    launch(MULT, 32'd3, 32'd4);
    repeat (19) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b1;
    tick();

    // randomized arithmetic
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = rnd();
      ry = ($urandom_range(0, 9) == 0) ? 32'd0 : rnd();
      run_op("rand", ro, rx, ry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Iterative HI/LO multiply/divide unit for the mMIPS execute stage. It computes MULT, MULTU, DIV and DIVU over 32 cycles and handles MTHI/MTLO in a single cycle. Its `hi`/`lo` registers feed the execute-stage result MUX4 that serves MFHI/MFLO. Its `busy` output drives the hazard/stall logic that freezes the pipeline while an operation is in flight.

## Interface
- `WIDTH`, default `DWORD` (32): operand and HI/LO width; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `abort`  in  1  synchronous cancel (pipeline flush).
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a MULT/DIV result is written.
- `div_by_zero`  out  1  one-cycle pulse with `done` when a DIV/DIVU had `b` = 0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX. Internal iteration counter `cnt` is ceil(log2(WIDTH+1)) bits wide.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Latch magnitudes of `a` and `b`. For signed ops, take two's-complement absolute values; for unsigned ops, use the raw values.
  - Latch result signs: quotient/product sign = a[msb]^b[msb]; remainder sign = a[msb]. Latch the op and the divisor-zero flag.
  - Set `cnt`=0 and go to RUN.
- IDLE, `start`=1, op MTHI/MTLO: write `a` to `hi`/`lo` at that edge. Stay in IDLE; no `busy`, no `done`.
- IDLE, `start`=1, op 110/111: nothing happens.
- RUN, multiply: radix-2 shift-add, 2·WIDTH-bit accumulator, one multiplier bit per edge.
- RUN, divide: restoring shift-subtract, one quotient bit per edge.
- RUN: `cnt` increments each edge. On the edge where `cnt` reaches WIDTH, go to FIX.
- FIX, one edge:
  - Apply sign correction (negate when the latched sign is 1 and the op is signed).
  - MULT/MULTU: `hi` = upper half of the product, `lo` = lower half.
  - DIV/DIVU: `lo` = quotient, `hi` = remainder.
  - Pulse `done`; go to IDLE.
- Divide by zero: full latency is kept. `lo` = all ones, `hi` = `a` as captured (raw, sign not applied). `div_by_zero` pulses with `done`.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0. This is the natural truncation; no special case.
- `start` while `busy`=1: ignored, no queuing. The hazard logic must hold the instruction until `busy` falls.
- `abort`=1 in RUN or FIX: return to IDLE at that edge. `hi`/`lo` unchanged, no `done`. `abort` has priority over a FIX write.
- `abort`=1 in IDLE: suppresses a simultaneous `start`, including MTHI/MTLO.
- All arithmetic is mod 2^WIDTH per half; overflow bits are discarded.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `busy`=0, `done`=0, `div_by_zero`=0; `hi`=0, `lo`=0; `cnt`=0.
- Reset asserted mid-operation aborts immediately and clears `hi`/`lo`.
- `start` accepted at edge k:
  - `busy` is high from edge k through edge k+WIDTH+1, i.e. WIDTH+1 cycles (33 for WIDTH=32).
  - RUN iterates on edges k+1 … k+WIDTH.
  - FIX writes at edge k+WIDTH+1; `hi`/`lo` show the new values from that edge.
  - `done` is high for exactly the cycle after edge k+WIDTH+1.
- A new `start` is accepted in the same cycle `done` is high (back-to-back: the next op starts at edge k+WIDTH+2).
- MTHI/MTLO: result visible one edge after `start`. `busy` never rises.
- `hi`/`lo` are stable (hold their previous values) throughout RUN, so MFHI/MFLO issued during `busy` is a hazard-unit stall, not a glitch.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE; `done` exactly 33 cycles after the start edge; `busy` high for 33 cycles.
- MULTU, same operands -> `hi`=0x00000001, `lo`=0xFFFFFFFE. Then MTHI a=0x12345678 -> `hi`=0x12345678 next edge with `busy`=0.
- DIV a=0xFFFFFFF9 (−7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU a=100, b=0 -> `lo`=0xFFFFFFFF, `hi`=100, `div_by_zero` pulses with `done`. DIVU 100/7 -> `lo`=14, `hi`=2.
- Start DIVU 100/7, then assert `start` with MULT at cycle 10 -> the second request is ignored; result is DIVU only. Then issue back-to-back ops, the second `start` coincident with `done` -> both results are correct.
- MULT started with `hi`/`lo`=0xAAAAAAAA: `abort` at cycle 20 -> `hi`/`lo` unchanged, no `done`. Repeat with `rst`=0 at cycle 20 -> `hi`=`lo`=0, `busy`=0 immediately.
